// File: rtl/mda_pkg.sv
// Shared definitions for the MDA-to-HDMI port controller.
//   - colour-select codes as seen on colour_sel
//   - lock FSM state encoding
//   - default MDA timing values used as parameter defaults
//   - output status bundle and a small range-check helper
package mda_pkg;

  localparam logic [1:0] COL_GREEN  = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_WHITE  = 2'b10;
  localparam logic [1:0] COL_RED    = 2'b11;

  localparam int unsigned LINES_W = 10;

  // 16.257 MHz pixel clock, ~370 lines per frame
  localparam int unsigned MDA_DEBOUNCE_CYCLES = 162570;  // 10 ms
  localparam int unsigned MDA_LINES_MIN       = 360;
  localparam int unsigned MDA_LINES_MAX       = 380;
  localparam int unsigned MDA_LOCK_FRAMES     = 4;
  localparam int unsigned MDA_VSYNC_TIMEOUT   = 524288;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  // Everything the port datapath sees, registered together
  typedef struct packed {
    logic [1:0]         colour;
    logic               locked;
    logic [LINES_W-1:0] line_count;
  } port_status_t;

  function automatic logic in_range(input logic [LINES_W-1:0] v,
                                    input logic [LINES_W-1:0] lo,
                                    input logic [LINES_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/mda_port_ctrl_if.sv
// Port bundle between the raw CRTC/switch side and the port controller.
//   master : drives raw hsync/vsync/switch2/switch3, observes status
//   slave  : the controller; receives raw inputs, drives colour_sel,
//            video_en, locked, line_count
interface mda_port_ctrl_if;

  logic                        hsync;
  logic                        vsync;
  logic                        switch2;
  logic                        switch3;
  logic [1:0]                  colour_sel;
  logic                        video_en;
  logic                        locked;
  logic [mda_pkg::LINES_W-1:0] line_count;

  modport master (
    output hsync, vsync, switch2, switch3,
    input  colour_sel, video_en, locked, line_count
  );

  modport slave (
    input  hsync, vsync, switch2, switch3,
    output colour_sel, video_en, locked, line_count
  );

endinterface

// File: rtl/mda_sync_debounce.sv
// Two-flop synchroniser plus stability filter for a W-bit switch code.
// A code is accepted into pending_o once it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive synchronised samples.
//   clk, rst_n : clock, async active-low reset
//   raw_i      : asynchronous switch inputs
//   pending_o  : last accepted (debounced) code
module mda_sync_debounce
  import mda_pkg::*;
#(
  parameter int unsigned W               = 2,
  parameter int unsigned DEBOUNCE_CYCLES = MDA_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] pending_o
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0][W-1:0] sync_q;
  logic [W-1:0]      cand_q, cand_d;
  logic [W-1:0]      pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (sync_q[1] != cand_q) begin
      cand_d = sync_q[1];
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Counter parks at CNT_LAST, so this keeps re-loading the same value
    if (cnt_q == CNT_LAST) pending_d = cand_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/mda_port_ctrl.sv
// MDA-to-HDMI port control.
//   - synchronises hsync/vsync, detects rising edges
//   - debounces the colour switches, applies a new code only at vsync
//   - counts lines per frame and runs the SEARCH/CHECK/LOCKED sync-lock
//     FSM that gates video/DE until timing is stable
// Ports:
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : slave side of mda_port_ctrl_if (raw syncs/switches in,
//                colour_sel / video_en / locked / line_count out)
module mda_port_ctrl
  import mda_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = MDA_DEBOUNCE_CYCLES,
  parameter int unsigned LINES_MIN       = MDA_LINES_MIN,
  parameter int unsigned LINES_MAX       = MDA_LINES_MAX,
  parameter int unsigned LOCK_FRAMES     = MDA_LOCK_FRAMES,
  parameter int unsigned VSYNC_TIMEOUT   = MDA_VSYNC_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  mda_port_ctrl_if.slave bus
);

  localparam int unsigned        TW       = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
  localparam logic [TW-1:0]      T_LAST   = TW'(VSYNC_TIMEOUT - 1);
  localparam int unsigned        GW       = $clog2(LOCK_FRAMES) + 1;
  localparam logic [GW-1:0]      G_LAST   = GW'(LOCK_FRAMES - 1);
  localparam logic [LINES_W-1:0] L_MIN    = LINES_W'(LINES_MIN);
  localparam logic [LINES_W-1:0] L_MAX    = LINES_W'(LINES_MAX);
  localparam logic [LINES_W-1:0] LINE_SAT = '1;

  // [0] = hsync, [1] = vsync; bits [1:0] synchronise, bit 2 is edge history
  logic [1:0][2:0]     sq_q;
  logic                hs_rise, vs_rise;

  logic [1:0]          pending_code;

  lock_state_e         state_q, state_d;
  logic [GW-1:0]       good_q, good_d;
  logic [LINES_W-1:0]  lines_q, lines_d;
  logic [TW-1:0]       timer_q, timer_d;
  port_status_t        stat_q, stat_d;
  logic                frame_ok, timeout;

  assign hs_rise = sq_q[0][1] & ~sq_q[0][2];
  assign vs_rise = sq_q[1][1] & ~sq_q[1][2];

  mda_sync_debounce #(
    .W              (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    ({bus.switch2, bus.switch3}),
    .pending_o(pending_code)
  );

  always_comb begin
    lines_d  = lines_q;
    timer_d  = timer_q;
    good_d   = good_q;
    state_d  = state_q;
    stat_d   = stat_q;
    frame_ok = in_range(lines_q, L_MIN, L_MAX);
    timeout  = (timer_q == T_LAST);

    // An hsync edge coinciding with vsync belongs to the new frame
    if (vs_rise)
      lines_d = {{(LINES_W-1){1'b0}}, hs_rise};
    else if (hs_rise && (lines_q != LINE_SAT))
      lines_d = lines_q + 1'b1;

    // Timer parks at T_LAST so timeout stays asserted until vsync returns
    if (vs_rise)
      timer_d = '0;
    else if (!timeout)
      timer_d = timer_q + 1'b1;

    if (vs_rise) begin
      // pending_code is the registered value, so a same-cycle debounce
      // update lands at the following frame boundary
      stat_d.colour     = pending_code;
      stat_d.line_count = lines_q;
      case (state_q)
        SEARCH: begin
          state_d = CHECK;
          good_d  = '0;
        end
        CHECK: begin
          if (!frame_ok) begin
            good_d = '0;
          end else if (good_q == G_LAST) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_ok) state_d = SEARCH;
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
    end

    stat_d.locked = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q    <= '0;
      state_q <= SEARCH;
      good_q  <= '0;
      lines_q <= '0;
      timer_q <= '0;
      stat_q  <= '0;
    end else begin
      sq_q[0] <= {sq_q[0][1:0], bus.hsync};
      sq_q[1] <= {sq_q[1][1:0], bus.vsync};
      state_q <= state_d;
      good_q  <= good_d;
      lines_q <= lines_d;
      timer_q <= timer_d;
      stat_q  <= stat_d;
    end
  end

  assign bus.colour_sel = stat_q.colour;
  assign bus.locked     = stat_q.locked;
  assign bus.video_en   = stat_q.locked;
  assign bus.line_count = stat_q.line_count;

endmodule

// File: tb/tb_mda_port_ctrl.sv
module tb_mda_port_ctrl;
  import mda_pkg::*;

  localparam int unsigned D   = 16;
  localparam int unsigned LMN = 8;
  localparam int unsigned LMX = 12;
  localparam int unsigned LF  = 4;
  localparam int unsigned TO  = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mda_port_ctrl_if bus_if();

  mda_port_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .LINES_MIN      (LMN),
    .LINES_MAX      (LMX),
    .LOCK_FRAMES    (LF),
    .VSYNC_TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct {
    int         due;
    logic [1:0] col;
    logic       lk;
    logic [9:0] lc;
    int         tag;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_err  = 0;
  int         fr_n   = 0;
  int         vs_cyc = 0;
  logic [1:0] es_col = 2'b00;
  logic       es_lk  = 1'b0;
  logic [9:0] es_lc  = 10'd0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic expect_at(input int due, input logic [1:0] col, input logic lk,
                           input logic [9:0] lc, input int tag);
    exp_t e;
    e.due = due; e.col = col; e.lk = lk; e.lc = lc; e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        n_chk++;
        if (exp_q[i].due != cyc || bus_if.colour_sel !== exp_q[i].col ||
            bus_if.locked !== exp_q[i].lk || bus_if.video_en !== exp_q[i].lk ||
            bus_if.line_count !== exp_q[i].lc) begin
          n_err++;
          $display("FAIL chk%0d cyc=%0d: got col=%b lk=%b ven=%b lc=%0d, want col=%b lk=%b lc=%0d (due %0d)",
                   exp_q[i].tag, cyc, bus_if.colour_sel, bus_if.locked, bus_if.video_en,
                   bus_if.line_count, exp_q[i].col, exp_q[i].lk, exp_q[i].lc, exp_q[i].due);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic frame(input int n, input logic [1:0] col, input logic lk,
                       input logic [9:0] lc);
    fr_n++;
    vs_cyc = cyc;
    expect_at(cyc + 2, es_col, es_lk, es_lc, fr_n * 10);
    expect_at(cyc + 3, col, lk, lc, fr_n * 10 + 1);
    es_col = col; es_lk = lk; es_lc = lc;
    bus_if.vsync = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus_if.hsync = 1'b1;
      repeat (2) @(negedge clk);
      bus_if.hsync = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    bus_if.hsync   = 1'b0;
    bus_if.vsync   = 1'b0;
    bus_if.switch2 = 1'b0;
    bus_if.switch3 = 1'b0;

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    expect_at(cyc, 2'b00, 1'b0, 10'd0, 1);
    n_chk++;
    if (bus_if.colour_sel !== 2'b00 || bus_if.locked !== 1'b0 ||
        bus_if.video_en !== 1'b0 || bus_if.line_count !== 10'd0) begin
      n_err++;
      $display("FAIL chk2 reset: col=%b lk=%b ven=%b lc=%0d", bus_if.colour_sel,
               bus_if.locked, bus_if.video_en, bus_if.line_count);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 7; i++) expect_at(cyc + 50 * i, 2'b00, 1'b0, 10'd0, 100 + i);
    repeat (TO + 60) @(negedge clk);

    frame(10, 2'b00, 1'b0, 10'd0);
    for (int i = 0; i < 3; i++) frame(10, 2'b00, 1'b0, 10'd10);
    frame(6, 2'b00, 1'b1, 10'd10);
    n_chk++;
    if (bus_if.locked !== 1'b1 || bus_if.video_en !== 1'b1 || bus_if.line_count !== 10'd10) begin
      n_err++;
      $display("FAIL chk3 lock: lk=%b ven=%b lc=%0d", bus_if.locked, bus_if.video_en,
               bus_if.line_count);
    end

    frame(10, 2'b00, 1'b0, 10'd6);
    frame(8,  2'b00, 1'b0, 10'd10);
    frame(12, 2'b00, 1'b0, 10'd8);
    frame(13, 2'b00, 1'b0, 10'd12);
    frame(10, 2'b00, 1'b0, 10'd13);
    for (int i = 0; i < 3; i++) frame(10, 2'b00, 1'b0, 10'd10);

    fork
      frame(10, 2'b00, 1'b1, 10'd10);
      begin
        repeat (8) @(negedge clk);
        bus_if.switch2 = 1'b1;
        expect_at(cyc + 32, 2'b00, 1'b1, 10'd10, 200);
      end
    join

    fork
      frame(10, 2'b10, 1'b1, 10'd10);
      begin
        repeat (8) @(negedge clk);
        bus_if.switch3 = 1'b1;
        repeat (5) @(negedge clk);
        bus_if.switch3 = 1'b0;
      end
    join

    bus_if.switch3 = 1'b1;
    repeat (D) @(negedge clk);
    frame(10, 2'b10, 1'b1, 10'd10);
    frame(10, 2'b11, 1'b1, 10'd10);

    expect_at(vs_cyc + TO + 2, 2'b11, 1'b1, 10'd10, 300);
    expect_at(vs_cyc + TO + 3, 2'b11, 1'b0, 10'd10, 301);
    es_lk = 1'b0;
    repeat (TO) @(negedge clk);

    for (int i = 0; i < 4; i++) frame(10, 2'b11, 1'b0, 10'd10);
    frame(10, 2'b11, 1'b1, 10'd10);

    fork
      frame(10, 2'b11, 1'b1, 10'd10);
      begin
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        expect_at(cyc, 2'b00, 1'b0, 10'd0, 400);
        #1;
        n_chk++;
        if (bus_if.colour_sel !== 2'b00 || bus_if.locked !== 1'b0 ||
            bus_if.video_en !== 1'b0 || bus_if.line_count !== 10'd0) begin
          n_err++;
          $display("FAIL chk402 async reset: col=%b lk=%b ven=%b lc=%0d", bus_if.colour_sel,
                   bus_if.locked, bus_if.video_en, bus_if.line_count);
        end
      end
    join
    rst_n = 1'b1;
    es_col = 2'b00; es_lk = 1'b0; es_lc = 10'd0;
    expect_at(cyc + 25, 2'b00, 1'b0, 10'd0, 401);
    repeat (30) @(negedge clk);

    frame(10, 2'b11, 1'b0, 10'd0);
    for (int i = 0; i < 3; i++) frame(10, 2'b11, 1'b0, 10'd10);
    frame(10, 2'b11, 1'b1, 10'd10);

    repeat (10) @(negedge clk);
    n_chk++;
    if (bus_if.colour_sel !== 2'b11 || bus_if.locked !== 1'b1 ||
        bus_if.video_en !== 1'b1 || bus_if.line_count !== 10'd10) begin
      n_err++;
      $display("FAIL chk500 relock: col=%b lk=%b ven=%b lc=%0d", bus_if.colour_sel,
               bus_if.locked, bus_if.video_en, bus_if.line_count);
    end
    while (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL chk%0d never compared (due %0d, now %0d)", exp_q[0].tag, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
